// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage types and constants.
// Bus layouts, CP0 register addresses and exception codes.
package wb_stage_pkg;

  localparam int MS_TO_WS_BUS_WD   = 124;
  localparam int WS_FWD_BLK_BUS_WD = 41;

  localparam logic [7:0] CP0_BADVADDR = 8'd64;
  localparam logic [7:0] CP0_COUNT    = 8'd72;
  localparam logic [7:0] CP0_COMPARE  = 8'd88;
  localparam logic [7:0] CP0_STATUS   = 8'd96;
  localparam logic [7:0] CP0_CAUSE    = 8'd104;
  localparam logic [7:0] CP0_EPC      = 8'd112;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] STATUS_RST = 32'h0040_0000;

  typedef struct packed {
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic [7:0]  cp0_addr;
    logic        ex;
    logic        bd;
    logic        eret;
    logic        syscall;
    logic        mfc0;
    logic        mtc0;
    logic [3:0]  gr_strb;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_ws_t;

endpackage

// File: rtl/wb_stage_cp0_regs.sv
// CP0 register file: Status, Cause, EPC, BadVAddr, Count, Compare.
// Also owns the timer and the interrupt-pending condition.
module cp0_regs
  import wb_stage_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ex,
  input  logic [4:0]  i_excode,
  input  logic        i_bd,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_badvaddr,
  input  logic        i_eret,
  input  logic        i_mtc0,
  input  logic [7:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [5:0]  i_ext_int,
  output logic [31:0] o_rdata,
  output logic [31:0] o_epc,
  output logic        o_int_pend
);

  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic        r_ti;
  logic [7:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [31:0] r_div;

  logic        w_wr_count;
  logic        w_wr_cmp;
  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic        w_wrap;
  logic        w_addr_ex;
  logic [31:0] w_count_nxt;
  logic [31:0] w_cmp_nxt;
  logic        w_ti_nxt;

  assign w_wr_count  = i_mtc0 & (i_addr == CP0_COUNT);
  assign w_wr_cmp    = i_mtc0 & (i_addr == CP0_COMPARE);
  assign w_wr_status = i_mtc0 & (i_addr == CP0_STATUS);
  assign w_wr_cause  = i_mtc0 & (i_addr == CP0_CAUSE);
  assign w_wr_epc    = i_mtc0 & (i_addr == CP0_EPC);

  assign w_wrap    = (r_div == 32'(COUNT_DIV - 1));
  assign w_addr_ex = (i_excode == EXC_ADEL) |
                     (i_excode == EXC_ADES);

  assign w_count_nxt = w_wr_count ? i_wdata :
                       r_count + {31'b0, w_wrap};
  assign w_cmp_nxt   = w_wr_cmp ? i_wdata : r_compare;
  // TI is sticky until software rewrites Compare
  assign w_ti_nxt    = ~w_wr_cmp &
                       (r_ti | (w_count_nxt == w_cmp_nxt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ti       <= 1'b0;
      r_ip       <= '0;
      r_exccode  <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_count    <= '0;
      r_compare  <= '0;
      r_div      <= '0;
    end else begin
      r_count   <= w_count_nxt;
      r_compare <= w_cmp_nxt;
      r_ti      <= w_ti_nxt;
      r_ip[7:2] <= {i_ext_int[5] | r_ti, i_ext_int[4:0]};
      if (w_wr_count || w_wrap) r_div <= '0;
      else                      r_div <= r_div + 32'd1;
      if (w_wr_cause) r_ip[1:0] <= i_wdata[9:8];
      if (i_ex) begin
        r_exl     <= 1'b1;
        r_exccode <= i_excode;
        if (!r_exl) begin
          r_bd  <= i_bd;
          r_epc <= i_bd ? i_pc - 32'd4 : i_pc;
        end
        if (w_addr_ex) r_badvaddr <= i_badvaddr;
      end else if (i_eret) begin
        r_exl <= 1'b0;
      end else if (w_wr_status) begin
        r_im  <= i_wdata[15:8];
        r_exl <= i_wdata[1];
        r_ie  <= i_wdata[0];
      end else if (w_wr_epc) begin
        r_epc <= i_wdata;
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    unique case (i_addr)
      CP0_BADVADDR: o_rdata = r_badvaddr;
      CP0_COUNT:    o_rdata = r_count;
      CP0_COMPARE:  o_rdata = r_compare;
      CP0_STATUS:   o_rdata = {9'b0, 1'b1, 6'b0, r_im,
                               6'b0, r_exl, r_ie};
      CP0_CAUSE:    o_rdata = {r_bd, r_ti, 14'b0, r_ip,
                               1'b0, r_exccode, 2'b0};
      CP0_EPC:      o_rdata = r_epc;
      default:      o_rdata = '0;
    endcase
  end

  assign o_epc      = r_epc;
  assign o_int_pend = r_ie & ~r_exl & |(r_ip & r_im);

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: pipeline register, commit, flush/redirect,
// forwarding info and trace outputs; CP0 lives in cp0_regs.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY  = 32'hbfc0_0380,
  parameter int          COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ws_allowin,
  input  logic        ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [5:0]  ext_int_in,
  output logic [3:0]  rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [WS_FWD_BLK_BUS_WD-1:0] ws_fwd_blk_bus,
  output logic        ws_inst_mfc0_o,
  output logic        ws_ex,
  output logic        ws_eret,
  output logic [31:0] ex_redirect_pc,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  logic        r_ws_valid;
  ms_ws_t      r_bus;
  logic        w_int_pend;
  logic [4:0]  w_excode;
  logic [31:0] w_cp0_rdata;
  logic [31:0] w_epc;
  logic        w_mtc0;
  logic        w_unused;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ws_valid <= 1'b0;
      r_bus      <= '0;
    end else begin
      r_ws_valid <= ms_to_ws_valid;
      if (ms_to_ws_valid) r_bus <= ms_ws_t'(ms_to_ws_bus);
    end
  end

  assign ws_allowin = 1'b1;
  assign w_unused   = r_bus.syscall;

  // an attached exception outranks a pending interrupt
  assign ws_ex    = r_ws_valid & (r_bus.ex | w_int_pend);
  assign ws_eret  = r_ws_valid & r_bus.eret & ~ws_ex;
  assign w_excode = r_bus.ex ? r_bus.excode : EXC_INT;
  assign w_mtc0   = r_ws_valid & r_bus.mtc0 & ~ws_ex;

  cp0_regs #(
    .COUNT_DIV (COUNT_DIV)
  ) u_cp0 (
    .clk        (clk),
    .rst_n      (resetn),
    .i_ex       (ws_ex),
    .i_excode   (w_excode),
    .i_bd       (r_bus.bd),
    .i_pc       (r_bus.pc),
    .i_badvaddr (r_bus.badvaddr),
    .i_eret     (ws_eret),
    .i_mtc0     (w_mtc0),
    .i_addr     (r_bus.cp0_addr),
    .i_wdata    (r_bus.result),
    .i_ext_int  (ext_int_in),
    .o_rdata    (w_cp0_rdata),
    .o_epc      (w_epc),
    .o_int_pend (w_int_pend)
  );

  always_comb begin
    ex_redirect_pc = '0;
    unique case (1'b1)
      ws_ex:   ex_redirect_pc = EX_ENTRY;
      ws_eret: ex_redirect_pc = w_epc;
      default: ex_redirect_pc = '0;
    endcase
  end

  assign rf_we    = {4{r_ws_valid & ~ws_ex}} & r_bus.gr_strb;
  assign rf_waddr = r_bus.dest;
  assign rf_wdata = r_bus.mfc0 ? w_cp0_rdata : r_bus.result;

  assign ws_fwd_blk_bus = {{4{r_ws_valid}} & r_bus.gr_strb,
                           r_bus.dest, rf_wdata};
  assign ws_inst_mfc0_o = r_ws_valid & r_bus.mfc0;

  assign debug_wb_pc       = r_bus.pc;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a queue of expected commits.
// CP0 state is observed through mfc0 read-back on rf_wdata.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ws_allowin;
  logic        ms_to_ws_valid = 1'b0;
  ms_ws_t      bus = '0;
  logic [5:0]  ext_int_in = '0;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [40:0] fwd;
  logic        mfc0_o;
  logic        ws_ex;
  logic        ws_eret;
  logic [31:0] rpc;
  logic [31:0] dpc;
  logic [3:0]  dwen;
  logic [4:0]  dwnum;
  logic [31:0] dwdata;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (bus),
    .ext_int_in        (ext_int_in),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_fwd_blk_bus    (fwd),
    .ws_inst_mfc0_o    (mfc0_o),
    .ws_ex             (ws_ex),
    .ws_eret           (ws_eret),
    .ex_redirect_pc    (rpc),
    .debug_wb_pc       (dpc),
    .debug_wb_rf_wen   (dwen),
    .debug_wb_rf_wnum  (dwnum),
    .debug_wb_rf_wdata (dwdata)
  );

  typedef struct {
    string       tag;
    ms_ws_t      b;
    logic        ex;
    logic        eret;
    logic [31:0] rpc;
    logic [31:0] wd;
    logic [31:0] mask;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   hit;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic ms_ws_t alu(input logic [3:0] s,
                                 input logic [4:0] d,
                                 input logic [31:0] r,
                                 input logic [31:0] pc);
    ms_ws_t b = '0;
    b.gr_strb = s;
    b.dest    = d;
    b.result  = r;
    b.pc      = pc;
    return b;
  endfunction

  function automatic ms_ws_t mf(input logic [7:0] a,
                                input logic [4:0] d,
                                input logic [31:0] pc);
    ms_ws_t b = alu(4'hf, d, 32'h5555_aaaa, pc);
    b.mfc0     = 1'b1;
    b.cp0_addr = a;
    return b;
  endfunction

  function automatic ms_ws_t mt(input logic [7:0] a,
                                input logic [31:0] v,
                                input logic [31:0] pc);
    ms_ws_t b = alu(4'h0, 5'd0, v, pc);
    b.mtc0     = 1'b1;
    b.cp0_addr = a;
    return b;
  endfunction

  function automatic ms_ws_t exc(input logic [4:0] c,
                                 input logic bd,
                                 input logic [31:0] pc,
                                 input logic [31:0] va);
    ms_ws_t b = alu(4'hf, 5'd3, 32'h0bad_0bad, pc);
    b.ex       = 1'b1;
    b.excode   = c;
    b.bd       = bd;
    b.badvaddr = va;
    b.syscall  = (c == EXC_SYS);
    return b;
  endfunction

  function automatic exp_t E(input string tag,
                             input ms_ws_t b,
                             input logic ex,
                             input logic er,
                             input logic [31:0] r,
                             input logic [31:0] wd,
                             input logic [31:0] m);
    exp_t e;
    e.tag  = tag;
    e.b    = b;
    e.ex   = ex;
    e.eret = er;
    e.rpc  = r;
    e.wd   = wd;
    e.mask = m;
    return e;
  endfunction

  task automatic issue(input exp_t e);
    exp_t x;
    logic [3:0] we;
    @(negedge clk);
    q.push_back(e);
    bus = e.b;
    ms_to_ws_valid = 1'b1;
    @(posedge clk);
    #1;
    x  = q.pop_front();
    we = x.ex ? 4'h0 : x.b.gr_strb;
    chk({x.tag, ".ex"}, 32'(ws_ex), 32'(x.ex));
    chk({x.tag, ".eret"}, 32'(ws_eret), 32'(x.eret));
    chk({x.tag, ".rpc"}, rpc, x.rpc);
    chk({x.tag, ".we"}, 32'(rf_we), 32'(we));
    chk({x.tag, ".dwen"}, 32'(dwen), 32'(we));
    chk({x.tag, ".wa"}, 32'(dwnum), 32'(x.b.dest));
    chk({x.tag, ".dpc"}, dpc, x.b.pc);
    chk({x.tag, ".fwd"}, 32'(fwd[40:32]),
        32'({x.b.gr_strb, x.b.dest}));
    chk({x.tag, ".mf"}, 32'(mfc0_o), 32'(x.b.mfc0));
    if (x.mask != 0) begin
      chk({x.tag, ".wd"}, rf_wdata & x.mask, x.wd);
      chk({x.tag, ".dwd"}, dwdata & x.mask, x.wd);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    ms_to_ws_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".we"}, 32'(rf_we), 0);
    chk({tag, ".wa"}, 32'(rf_waddr), 0);
    chk({tag, ".wd"}, rf_wdata, 0);
    chk({tag, ".fwd"}, fwd[31:0] | 32'(fwd[40:32]), 0);
    chk({tag, ".flush"}, 32'({ws_ex, ws_eret, mfc0_o}), 0);
    chk({tag, ".rpc"}, rpc, 0);
    chk({tag, ".dpc"}, dpc, 0);
    chk({tag, ".allowin"}, 32'(ws_allowin), 1);
  endtask

  localparam logic [31:0] EXE  = 32'hbfc0_0380;
  localparam logic [31:0] ALL  = 32'hffff_ffff;
  localparam logic [31:0] NONE = 32'h0;

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("rst");
    resetn = 1'b1;

    issue(E("st_rst", mf(CP0_STATUS, 5'd1, 32'hbfc0_00f0),
            0, 0, 0, STATUS_RST, ALL));
    issue(E("lwl", alu(4'b1100, 5'd5, 32'h1234_0000,
                       32'hbfc0_00fc),
            0, 0, 0, 32'h1234_0000, ALL));
    issue(E("sys_bd", exc(EXC_SYS, 1'b1, 32'hbfc0_0104, 0),
            1, 0, EXE, 0, NONE));
    issue(E("sys_epc", mf(CP0_EPC, 5'd2, 32'hbfc0_0380),
            0, 0, 0, 32'hbfc0_0100, ALL));
    issue(E("sys_cause", mf(CP0_CAUSE, 5'd2, 32'hbfc0_0384),
            0, 0, 0, 32'h8000_0020, 32'h8000_007c));
    issue(E("sys_st", mf(CP0_STATUS, 5'd2, 32'hbfc0_0388),
            0, 0, 0, 32'h0040_0002, ALL));

    issue(E("adel", exc(EXC_ADEL, 1'b0, 32'hbfc0_038c,
                        32'h0000_0003),
            1, 0, EXE, 0, NONE));
    issue(E("adel_epc", mf(CP0_EPC, 5'd4, 32'hbfc0_0380),
            0, 0, 0, 32'hbfc0_0100, ALL));
    issue(E("adel_bva", mf(CP0_BADVADDR, 5'd4, 32'hbfc0_0384),
            0, 0, 0, 32'h0000_0003, ALL));
    issue(E("adel_cause", mf(CP0_CAUSE, 5'd4, 32'hbfc0_0388),
            0, 0, 0, 32'h8000_0010, 32'h8000_007c));

    issue(E("bva_ro", mt(CP0_BADVADDR, 32'hdead_beef,
                         32'hbfc0_038c), 0, 0, 0, 0, NONE));
    issue(E("bva_rd", mf(CP0_BADVADDR, 5'd6, 32'hbfc0_0390),
            0, 0, 0, 32'h0000_0003, ALL));
    issue(E("cause_wr", mt(CP0_CAUSE, ALL, 32'hbfc0_0394),
            0, 0, 0, 0, NONE));
    issue(E("cause_rd", mf(CP0_CAUSE, 5'd6, 32'hbfc0_0398),
            0, 0, 0, 32'h8000_0310, 32'h8000_037c));
    issue(E("cause_clr", mt(CP0_CAUSE, 0, 32'hbfc0_039c),
            0, 0, 0, 0, NONE));

    issue(E("epc_wr", mt(CP0_EPC, 32'hbfc0_0200, 32'hbfc0_03a0),
            0, 0, 0, 0, NONE));
    begin
      ms_ws_t b = alu(4'h0, 5'd0, 0, 32'hbfc0_03a4);
      b.eret = 1'b1;
      issue(E("eret", b, 0, 1, 32'hbfc0_0200, 0, NONE));
    end
    issue(E("eret_st", mf(CP0_STATUS, 5'd7, 32'hbfc0_0200),
            0, 0, 0, STATUS_RST, ALL));
    idle();

    issue(E("cnt_wr", mt(CP0_COUNT, 0, 32'hbfc0_0204),
            0, 0, 0, 0, NONE));
    issue(E("cmp_wr", mt(CP0_COMPARE, 32'd10, 32'hbfc0_0208),
            0, 0, 0, 0, NONE));
    issue(E("st_ie", mt(CP0_STATUS, 32'h0000_8001, 32'hbfc0_020c),
            0, 0, 0, 0, NONE));
    hit = -1;
    for (int i = 0; i < 60 && hit < 0; i++) begin
      @(negedge clk);
      bus = mf(CP0_CAUSE, 5'd8, 32'hbfc0_0300 + 32'(4 * i));
      ms_to_ws_valid = 1'b1;
      @(posedge clk);
      #1;
      if (ws_ex) begin
        hit = i;
        chk("tmr_rpc", rpc, EXE);
        chk("tmr_we", 32'(rf_we), 0);
      end
    end
    chk("tmr_latency", 32'(hit), 32'd19);
    issue(E("tmr_cause", mf(CP0_CAUSE, 5'd9, 32'hbfc0_0380),
            0, 0, 0, 32'h4000_0000, 32'h4000_007c));
    issue(E("tmr_st", mf(CP0_STATUS, 5'd9, 32'hbfc0_0384),
            0, 0, 0, 32'h0040_8003, ALL));
    issue(E("cmp_clr", mt(CP0_COMPARE, 32'h100, 32'hbfc0_0388),
            0, 0, 0, 0, NONE));
    issue(E("ti_clr", mf(CP0_CAUSE, 5'd9, 32'hbfc0_038c),
            0, 0, 0, 32'h0, 32'h4000_0000));

    issue(E("st_mid", mt(CP0_STATUS, 32'h0000_ff03,
                         32'hbfc0_0390), 0, 0, 0, 0, NONE));
    resetn = 1'b0;
    #1;
    chk_zero("rst_mid");
    idle();
    @(negedge clk);
    resetn = 1'b1;
    issue(E("rst_st", mf(CP0_STATUS, 5'd10, 32'hbfc0_0000),
            0, 0, 0, STATUS_RST, ALL));
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (writeback) pipeline stage. Consumes the memory-stage bundle and commits the result to the register file with per-byte strobes (needed for lwl/lwr).
- Owns CP0: Status, Cause, EPC, BadVAddr, Count, Compare.
- Detects exceptions and interrupts, then drives flush and redirect (ws_ex / ws_eret) to all upstream stages.
- Supplies forwarding/blocking information and trace-debug signals.

Parameters:
- EX_ENTRY, 32'hbfc00380, exception handler PC driven on ws_ex
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles (must be ≥1)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ws_allowin  out  1  stage can accept the memory-stage bundle
- ms_to_ws_valid  in  1  memory-stage bundle valid
- ms_to_ws_bus  in  124  {excode[123:119], badvaddr[118:87], cp0_addr[86:79], ex[78], bd[77], eret[76], syscall[75], mfc0[74], mtc0[73], gr_strb[72:69], dest[68:64], result[63:32], pc[31:0]}
- ext_int_in  in  6  external hardware interrupts, level-sensitive
- rf_we  out  4  register-file byte write strobes
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- ws_fwd_blk_bus  out  41  {fwd_valid[40:37], dest[36:32], data[31:0]}
- ws_inst_mfc0_o  out  1  valid mfc0 in stage; upstream stages block on it
- ws_ex  out  1  exception commit this cycle (flush)
- ws_eret  out  1  eret commit this cycle (flush)
- ex_redirect_pc  out  32  EX_ENTRY when ws_ex, EPC when ws_eret
- debug_wb_pc  out  32  PC of the committing instruction
- debug_wb_rf_wen  out  4  equals rf_we
- debug_wb_rf_wnum  out  5  equals rf_waddr
- debug_wb_rf_wdata  out  32  equals rf_wdata

Behaviour:
- Single-cycle stage.
  - ws_ready_go=1 and ws_allowin=1.
  - ws_valid is loaded with ms_to_ws_valid every cycle. The bus register loads only when ms_to_ws_valid=1.
- Reset (async, resetn=0):
  - ws_valid=0; all outputs 0.
  - Status = 32'h0040_0000 (BEV=1, IM=0, EXL=0, IE=0).
  - Cause, EPC, BadVAddr, Count, Compare = 0; tick divider = 0.
  - Reset asserted mid-instruction discards that instruction; no CP0 update occurs.
- Interrupt pending: int_pend = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
  - Cause.IP[7:2] = {ext_int_in[5] | Cause.TI, ext_int_in[4:0]}, sampled each cycle.
  - Cause.IP[1:0] are software-written.
- Commit rules:
  - ws_ex = ws_valid & (bus.ex | int_pend). Interrupt has lower priority than an attached exception. ExcCode = bus.ex ? bus.excode : 0.
  - ws_eret = ws_valid & bus.eret & ~ws_ex.
  - rf_we = {4{ws_valid & ~ws_ex}} & gr_strb.
  - rf_wdata = bus.mfc0 ? cp0_rdata(cp0_addr) : bus.result.
- CP0 update on ws_ex, at the clock edge:
  - If Status.EXL=0: EPC = bd ? pc-4 : pc, and Cause.BD = bd.
  - Status.EXL = 1; Cause.ExcCode = ExcCode.
  - BadVAddr = bus.badvaddr only when ExcCode is 4 (AdEL) or 5 (AdES).
- eret: Status.EXL cleared.
- mtc0 (ws_valid & mtc0 & ~ws_ex) writes by cp0_addr={rd,sel}:
  - 8'd64 BadVAddr: read-only, write ignored.
  - 8'd72 Count: full write; divider cleared.
  - 8'd88 Compare: full write; clears Cause.TI.
  - 8'd96 Status: writes IM[15:8], EXL[1], IE[0] only.
  - 8'd104 Cause: writes IP[9:8] only.
  - 8'd112 EPC: full write.
  - Unlisted addresses read 0.
- Count:
  - Increments when the divider wraps, mod 2^32 (0xffffffff→0).
  - An mtc0 Count write in the same cycle wins over the increment.
- Timer: Cause.TI is set when Count==Compare (checked after update) and no Compare write occurs that cycle. A Compare write takes priority and clears TI.
- Same-cycle priority: an exception suppresses mtc0, rf write and eret.
- Forwarding: fwd_valid = {4{ws_valid}} & gr_strb, including during ws_ex, so upstream stalls stay conservative.
- ws_inst_mfc0_o = ws_valid & mfc0.
- Debug signals mirror the rf outputs; debug_wb_pc = bus.pc.

Decomposition:
- Shared package/header (mycpu.h):
  - MS_TO_WS_BUS_WD=124, WS_FWD_BLK_BUS_WD=41.
  - CP0 address constants (CP0_BADVADDR..CP0_EPC).
  - ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12).
  - Status reset value.
- One sub-module: cp0_regs, holding the CP0 registers, Count/Compare timer, interrupt-pending logic and read mux.
- wb_stage keeps the pipeline register, commit logic and rf/debug outputs.

Test Plan:
- Load-left commit: bus gr_strb=4'b1100, dest=5, result=32'h1234_0000 → rf_we=4'b1100, rf_waddr=5, rf_wdata=32'h1234_0000, ws_ex=0.
- Syscall in delay slot: ex=1, excode=8, bd=1, pc=32'hbfc0_0104 → ws_ex=1, ex_redirect_pc=32'hbfc0_0380, rf_we=0; next cycle EPC=32'hbfc0_0100, Cause.BD=1, Cause.ExcCode=8, Status.EXL=1.
- Nested exception with EXL=1: second AdEL, badvaddr=32'h0000_0003 → EPC unchanged, BadVAddr=32'h3, ExcCode=4.
- Return: mtc0 EPC=32'hbfc0_0200, then eret → ws_eret=1, ex_redirect_pc=32'hbfc0_0200, EXL=0.
- Timer interrupt: Compare=10, Count=0, Status IE=1, IM7=1 → TI set when Count reaches 10 (COUNT_DIV=2, about 20 cycles); next valid instruction → ws_ex=1, ExcCode=0; writing Compare clears TI.
- Reset mid-stream: resetn pulled low while a valid mtc0 Status is in the stage → all outputs 0, Status=32'h0040_0000, no write occurs.
